mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between instruction fetch (IF) and data memory access (DM).
- Serialises requests, times the memory latency with a down-counter, and returns read data with a one-cycle ack pulse.
- Drives `pipe_en`, the common enable for the pipeline's enabled registers, so the pipeline freezes while any access is outstanding.

Parameters:
- ADDR_WIDTH, 32, memory address width.
- DATA_WIDTH, 32, memory data width.
- MEM_LATENCY, 2, cycles from the `mem_en` cycle to valid `mem_rdata`; legal values 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request, level; held until if_ack.
- if_addr  in  ADDR_WIDTH  fetch address; stable while if_req is high.
- if_rdata  out  DATA_WIDTH  fetched word; registered.
- if_ack  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request, level; held until dm_ack.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  ADDR_WIDTH  data address.
- dm_wdata  in  DATA_WIDTH  store data.
- dm_rdata  out  DATA_WIDTH  load data; registered.
- dm_ack  out  1  one-cycle completion pulse for data.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable; valid with mem_en.
- mem_addr  out  ADDR_WIDTH  memory address; valid with mem_en.
- mem_wdata  out  DATA_WIDTH  memory write data; valid with mem_en.
- mem_rdata  in  DATA_WIDTH  memory read data; valid MEM_LATENCY cycles after the mem_en cycle.
- pipe_en  out  1  pipeline register enable; combinational.

Behaviour:
- Reset (synchronous, high at a clk edge):
  - state=IDLE, cnt=0, owner=DM.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0.
  - Round-robin pointer = DM.
  - Reset mid-access aborts the access silently: no ack is issued, and the memory result is dropped.
- All outputs except pipe_en are registered.
- FSM states: IDLE, WAIT.
- IDLE:
  - Eligible requesters are if_req and dm_req, with a requester masked in the cycle its own ack is high.
  - If any requester is eligible, select one (default: DM wins).
  - At the edge: mem_en<=1; drive mem_we/mem_addr/mem_wdata from the winner (mem_we=0 and mem_wdata=0 for IF); owner<=winner; cnt<=MEM_LATENCY; state<=WAIT.
  - If no requester is eligible, stay in IDLE with mem_en<=0.
- WAIT:
  - mem_en<=0, mem_we<=0; mem_addr and mem_wdata hold.
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0:
    - Load: owner rdata<=mem_rdata.
    - Store: dm_rdata holds its value.
    - owner ack<=1 for exactly one cycle; state<=IDLE.
- Latency: request first seen in cycle t → mem_en high in cycle t+1 → ack and rdata valid in cycle t+MEM_LATENCY+2.
- Back-to-back: in the ack cycle the other requester is eligible and issues, giving a new mem_en in the cycle after ack. A requester that was just acked cannot re-issue until one cycle after its ack.
- Simultaneous if_req and dm_req in IDLE: one is served and the other waits; it is issued in the loser's first eligible IDLE cycle.
- A request asserted during WAIT is not sampled until the FSM returns to IDLE.
- pipe_en = ~((if_req & ~if_ack) | (dm_req & ~dm_ack)):
  - 1 when nothing is outstanding;
  - 0 from the first request cycle up to, but not including, the ack cycle;
  - 1 in the ack cycle if the other requester is idle.
- No ack is ever issued without a matching prior request.
- if_ack and dm_ack are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. On a conflict, the winner is the requester not served last. The pointer updates on each issue and resets to DM. A continuously asserted DM cannot starve IF.
- Undefined: fixed priority, DM always beats IF. The pointer logic is absent.

Test Plan:
- Single fetch, MEM_LATENCY=2, if_req at cycle 1, if_addr=0x40, memory returns 0xDEADBEEF → mem_en=1 with mem_addr=0x40 in cycle 2; if_ack=1 and if_rdata=0xDEADBEEF in cycle 5; pipe_en=0 in cycles 1-4.
- Store dm_we=1, dm_addr=0x100, dm_wdata=0x12345678 → mem_en=1, mem_we=1, mem_wdata=0x12345678 for one cycle; dm_ack pulses; dm_rdata is unchanged.
- if_req and dm_req both rise in cycle 1:
  - Without MEM_ARB_RR_EN: DM is issued in cycle 2 and acked in cycle 5; IF is issued in cycle 6 and acked in cycle 9.
  - With MEM_ARB_RR_EN and the last-served requester being DM: IF is issued first.
- RR mode with dm_req held high continuously and if_req high → issue order alternates DM, IF, DM, IF.
- reset asserted in WAIT, one cycle before the ack would occur → no ack pulse; all outputs are 0 at the next cycle; a new request after reset issues normally.
- MEM_LATENCY=1 fetch of 0xA5A5A5A5 → ack in cycle t+3; sweep MEM_LATENCY=1..4 and check the ack timing each time.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data access.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default build gives DM fixed priority over IF.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_ack,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  pipe_en
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY);

    state_t                  state_reg;
    owner_t                  owner_reg;
    logic [3:0]              cnt_reg;
    logic                    store_reg;
    logic                    mem_en_reg;
    logic                    mem_we_reg;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg;
    logic [DATA_WIDTH-1:0]   mem_wdata_reg;
    logic                    if_ack_reg;
    logic                    dm_ack_reg;
    logic [DATA_WIDTH-1:0]   if_rdata_reg;
    logic [DATA_WIDTH-1:0]   dm_rdata_reg;

    logic if_elig;
    logic dm_elig;
    logic any_elig;
    logic grant_dm;

    // A requester whose ack is high this cycle is still holding req from the finished access.
    assign if_elig  = if_req & ~if_ack_reg;
    assign dm_elig  = dm_req & ~dm_ack_reg;
    assign any_elig = if_elig | dm_elig;

`ifdef MEM_ARB_RR_EN
    owner_t last_reg;

    assign grant_dm = dm_elig & (~if_elig | (last_reg == OWN_IF));

    always_ff @(posedge clk) begin
        if (reset) begin
            last_reg <= OWN_DM;
        end else if (state_reg == ST_IDLE && any_elig) begin
            last_reg <= grant_dm ? OWN_DM : OWN_IF;
        end
    end
`else
    assign grant_dm = dm_elig;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= OWN_DM;
            cnt_reg       <= 4'd0;
            store_reg     <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            if_ack_reg    <= 1'b0;
            dm_ack_reg    <= 1'b0;
            if_rdata_reg  <= '0;
            dm_rdata_reg  <= '0;
        end else begin
            if_ack_reg <= 1'b0;
            dm_ack_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    mem_en_reg <= any_elig;
                    if (any_elig) begin
                        mem_we_reg    <= grant_dm & dm_we;
                        store_reg     <= grant_dm & dm_we;
                        mem_addr_reg  <= grant_dm ? dm_addr : if_addr;
                        mem_wdata_reg <= grant_dm ? dm_wdata : '0;
                        owner_reg     <= grant_dm ? OWN_DM : OWN_IF;
                        cnt_reg       <= LAT_LOAD;
                        state_reg     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    mem_en_reg <= 1'b0;
                    mem_we_reg <= 1'b0;
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        state_reg <= ST_IDLE;
                        if (owner_reg == OWN_IF) begin
                            if_rdata_reg <= mem_rdata;
                            if_ack_reg   <= 1'b1;
                        end else begin
                            dm_ack_reg <= 1'b1;
                            if (!store_reg) begin
                                dm_rdata_reg <= mem_rdata;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign if_ack    = if_ack_reg;
    assign dm_ack    = dm_ack_reg;
    assign if_rdata  = if_rdata_reg;
    assign dm_rdata  = dm_rdata_reg;
    assign pipe_en   = ~any_elig;

endmodule
